// File: rtl/bcd_serial_counter_pkg.sv
// Shared types and constants for the serial BCD counter.
// Imported by the counter top and its digit incrementer.
package bcd_serial_counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic nib_ok(
    input logic [3:0] n
  );
    return n <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_serial_counter_inc.sv
// Single-digit BCD incrementer, time-shared by the counter.
// Passes the digit through untouched when not enabled.
module bcd_incrementer
  import bcd_serial_counter_pkg::*;
(
  input  logic [3:0] in,
  input  logic       en,
  output logic [3:0] out,
  output logic       carry
);

  always_comb begin
    out   = in;
    carry = 1'b0;
    if (en) begin
      if (in >= BCD_MAX) begin
        out   = 4'd0;
        carry = 1'b1;
      end else begin
        out = in + 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_serial_counter.sv
// Multi-digit BCD up-counter, one digit per clock through a
// shared incrementer; the ripple stops at the first no-carry.
module bcd_serial_counter
  import bcd_serial_counter_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ready,
  output logic                  done,
  output logic                  overflow,
  output logic                  err
);

  localparam int IW = $clog2(DIGITS);
  localparam int W  = 4 * DIGITS;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    bcd_q, bcd_d;
  logic            ovf_q, ovf_d;
  logic            err_q, err_d;

  logic [IW+1:0]   sel;
  logic [3:0]      inc_in;
  logic [3:0]      inc_out;
  logic            inc_en;
  logic            inc_carry;
  logic            ld_ok;

  assign sel    = {idx_q, 2'b00};
  assign inc_in = bcd_q[sel +: 4];

  bcd_incrementer u_inc (
    .in    (inc_in),
    .en    (inc_en),
    .out   (inc_out),
    .carry (inc_carry)
  );

  always_comb begin
    ld_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!nib_ok(load_val[4*i +: 4])) ld_ok = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    err_d   = 1'b0;
    inc_en  = 1'b0;
    if (clear) begin
      state_d = IDLE;
      idx_d   = '0;
      bcd_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load) begin
            if (ld_ok) bcd_d = load_val;
            else       err_d = 1'b1;
          end else if (start) begin
            state_d = RUN;
            idx_d   = '0;
          end
        end
        RUN: begin
          inc_en          = 1'b1;
          bcd_d[sel +: 4] = inc_out;
          // the top digit's carry-out is the wrap indication
          if (inc_carry && idx_q != IW'(DIGITS-1)) begin
            idx_d = idx_q + IW'(1);
          end else begin
            state_d = DONE;
            ovf_d   = inc_carry;
          end
        end
        DONE: begin
          state_d = IDLE;
          ovf_d   = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign bcd_out  = bcd_q;
  assign ready    = (state_q == IDLE);
  assign done     = (state_q == DONE);
  assign overflow = (state_q == DONE) && ovf_q;
  assign err      = err_q;

endmodule

// File: tb/tb_bcd_serial_counter.sv
// Bench for bcd_serial_counter: directed cases plus random
// traffic against a decimal-arithmetic reference model.
module tb_bcd_serial_counter;

  localparam int D = 4;
  localparam int W = 4 * D;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         clear;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] bcd_out;
  logic         ready;
  logic         done;
  logic         overflow;
  logic         err;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  bcd_serial_counter #(.DIGITS(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .bcd_out  (bcd_out),
    .ready    (ready),
    .done     (done),
    .overflow (overflow),
    .err      (err)
  );

  always #5 clk = ~clk;

  function automatic int pw(input int k);
    int r;
    r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  function automatic bit valid(input logic [W-1:0] v);
    for (int i = 0; i < D; i++)
      if (v[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int b2i(input logic [W-1:0] v);
    int r;
    r = 0;
    for (int i = D - 1; i >= 0; i--)
      r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] i2b(input int x);
    logic [W-1:0] r;
    int t;
    t = x;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // digits touched by +1: trailing nines plus one
  function automatic int ndig(input int x);
    int t, m;
    t = x;
    m = 1;
    while (t % 10 == 9 && m < D) begin
      t = t / 10;
      m++;
    end
    return m;
  endfunction

  int m_val, m_phase, m_old, m_new, m_k, m_m;
  bit m_err, m_wrap, m_e;

  always @(posedge clk) begin
    int p;
    m_e = 1'b0;
    if (reset) begin
      m_val   = 0;
      m_phase = 0;
      m_wrap  = 1'b0;
    end else if (clear) begin
      m_val   = 0;
      m_phase = 0;
    end else begin
      case (m_phase)
        0: begin
          if (load) begin
            if (valid(load_val)) m_val = b2i(load_val);
            else m_e = 1'b1;
          end else if (start) begin
            m_old   = m_val;
            m_new   = (m_val + 1) % pw(D);
            m_wrap  = (m_val == pw(D) - 1);
            m_m     = ndig(m_val);
            m_k     = 0;
            m_phase = 1;
          end
        end
        1: begin
          m_k++;
          p = pw(m_k);
          m_val = (m_old / p) * p + m_new % p;
          if (m_k == m_m) m_phase = 2;
        end
        default: m_phase = 0;
      endcase
    end
    m_err = m_e;
  end

  always @(negedge clk) begin
    logic [W-1:0] eb;
    logic er, ed, eo;
    if (chk_on) begin
      eb = i2b(m_val);
      er = (m_phase == 0);
      ed = (m_phase == 2);
      eo = ed && m_wrap;
      n_tests++;
      if (bcd_out !== eb || ready !== er || done !== ed ||
          overflow !== eo || err !== m_err) begin
        n_fail++;
        $display("FAIL model t=%0t: got bcd=%h rdy=%b dn=%b ov=%b er=%b, expected bcd=%h rdy=%b dn=%b ov=%b er=%b",
                 $time, bcd_out, ready, done, overflow, err,
                 eb, er, ed, eo, m_err);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load_val = v;
    load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  task automatic do_start(output int dc, output logic ov);
    start = 1'b1;
    cyc();
    start = 1'b0;
    dc = -1;
    ov = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (done === 1'b1) begin
        dc = c;
        ov = overflow;
        break;
      end
      cyc();
    end
    if (dc < 0) chk("done_timeout", 32'(dc), 32'd0);
  endtask

  int dc, nd;
  logic ov;
  logic [W-1:0] v;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    clear = 1'b0;
    load  = 1'b0;
    load_val = '0;
    cyc();
    chk_on = 1'b1;
    cyc();
    chk("rst_bcd", 32'(bcd_out), 32'h0);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    cyc();

    do_start(dc, ov);
    chk("cnt0_lat", 32'(dc), 32'd2);
    chk("cnt0_bcd", 32'(bcd_out), 32'h0001);
    chk("cnt0_ovf", 32'(ov), 32'd0);
    cyc();
    chk("cnt0_ready", 32'(ready), 32'd1);

    do_load(16'h0199);
    do_start(dc, ov);
    chk("c199_lat", 32'(dc), 32'd4);
    chk("c199_bcd", 32'(bcd_out), 32'h0200);
    chk("c199_rdy", 32'(ready), 32'd0);
    cyc();
    chk("c199_ready", 32'(ready), 32'd1);

    do_load(16'h9999);
    do_start(dc, ov);
    chk("wrap_lat", 32'(dc), 32'd5);
    chk("wrap_ovf", 32'(ov), 32'd1);
    chk("wrap_bcd", 32'(bcd_out), 32'h0000);
    cyc();

    do_load(16'h1234);
    do_load(16'h12A4);
    chk("bad_err", 32'(err), 32'd1);
    chk("bad_bcd", 32'(bcd_out), 32'h1234);
    cyc();
    chk("bad_err_end", 32'(err), 32'd0);

    load_val = 16'h0005;
    load = 1'b1;
    start = 1'b1;
    cyc();
    load = 1'b0;
    start = 1'b0;
    chk("ldst_ready", 32'(ready), 32'd1);
    chk("ldst_bcd", 32'(bcd_out), 32'h0005);
    nd = 0;
    for (int i = 0; i < 5; i++) begin
      if (done) nd++;
      cyc();
    end
    chk("ldst_nodone", 32'(nd), 32'd0);

    do_load(16'h0099);
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) nd++;
      cyc();
    end
    chk("busy_ndone", 32'(nd), 32'd1);
    chk("busy_bcd", 32'(bcd_out), 32'h0100);

    do_load(16'h0999);
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk("clr_bcd", 32'(bcd_out), 32'h0);
    chk("clr_ready", 32'(ready), 32'd1);
    chk("clr_done", 32'({done, overflow}), 32'd0);
    cyc();
    chk("clr_done2", 32'({done, overflow}), 32'd0);

    do_load(16'h0999);
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("mrst_bcd", 32'(bcd_out), 32'h0);
    chk("mrst_flags", 32'({ready, done, overflow, err}),
        32'b1000);
    do_start(dc, ov);
    chk("mrst_cnt", 32'(bcd_out), 32'h0001);
    chk("mrst_lat", 32'(dc), 32'd2);
    cyc();

    for (int i = 0; i < 800; i++) begin
      for (int j = 0; j < D; j++) begin
        v[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'd9
                      : 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 4) == 0)
        v[4*$urandom_range(0, D-1) +: 4] =
          4'($urandom_range(10, 15));
      load_val = v;
      load  = ($urandom_range(0, 9) == 0);
      start = ($urandom_range(0, 2) == 0);
      clear = ($urandom_range(0, 39) == 0);
      reset = ($urandom_range(0, 99) == 0);
      cyc();
    end
    load  = 1'b0;
    start = 1'b0;
    clear = 1'b0;
    reset = 1'b0;
    cyc();
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_serial_counter.md
Name: bcd_serial_counter

Overview:
Multi-digit BCD up-counter that time-shares one single-digit bcd_incrementer across DIGITS digit registers, one digit per clock. Carries ripple serially from the least significant digit, and the sequence stops early once a digit produces no carry. It sits between control logic that issues count requests and displays or loggers that read packed BCD.

Parameters:
DIGITS, 4, number of BCD digits held (≥2); digit 0 is least significant, at bcd_out[3:0].

Ports:
clk  input  1  system clock; all state changes on its rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request one increment; accepted only when ready=1.
clear  input  1  synchronous clear of all digits; aborts any operation in progress.
load  input  1  load load_val into the digits; accepted only when ready=1.
load_val  input  4*DIGITS  packed BCD value to load.
bcd_out  output  4*DIGITS  packed BCD count (registered).
ready  output  1  high in IDLE.
done  output  1  one-cycle pulse when an increment completes.
overflow  output  1  one-cycle pulse together with done when the count wraps from all-9s to 0.
err  output  1  one-cycle pulse when a load is rejected for a non-BCD nibble.

Behaviour:
- Clock/reset: one clock, clk; reset is synchronous and active-high on port reset.
- Reset values: bcd_out=0, state=IDLE, ready=1, done=0, overflow=0, err=0, digit index=0.
- Request priority within a cycle: reset > clear > load > start.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - load=1 with all nibbles ≤9: bcd_out<=load_val.
  - load=1 with any nibble >9: bcd_out unchanged; err=1 for the next cycle.
  - start=1 with no load: go to RUN, idx<=0.
  - load and start together: load wins; start is dropped.
- RUN:
  - ready=0; incrementer en=1, in=digit[idx].
  - Each edge writes digit[idx]<=inc_out.
  - If inc_carry=1 and idx<DIGITS-1: idx<=idx+1, stay in RUN.
  - Otherwise go to DONE; ovf_r<=inc_carry (set only when the top digit carries out).
- DONE: done=1, overflow=ovf_r, ready=0; next edge returns to IDLE with ovf_r cleared.
- Latency:
  - Start sampled at edge E0. m digits are processed on edges E1..Em. done is high in the cycle after Em. ready returns after E(m+1).
  - Therefore 1 ≤ m ≤ DIGITS, and an increment occupies m+2 cycles from start to the next ready.
- In IDLE and DONE, incrementer en=0; its outputs are ignored.
- start, load or err requests outside IDLE are ignored; no queuing.
- clear in any state: all digits<=0, state<=IDLE, no done/overflow pulse; a concurrent load or start is dropped.
- Reset in any state: identical to the power-on reset values.
- Wrap-around: 9…9 +1 gives 0…0, with overflow=1 coincident with done.
- Digits never hold a non-BCD code, because load validation guarantees it.

Decomposition:
- Shared package constants: state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and BCD_MAX=4'd9.
- One sub-module: bcd_incrementer (in[3:0], en, out[3:0], carry), instantiated once and driven by a digit mux on idx.
- Digit write-back uses the idx demux inside this block.

Test Plan:
- Counting from 0: reset, then start (DIGITS=4) → bcd_out=16'h0001; done high 2 cycles after start; overflow=0; ready back 3 cycles after start.
- Multi-digit carry: load 16'h0199, then start → bcd_out=16'h0200; 3 RUN cycles; done 4 cycles after start; ready low 4 cycles.
- Full wrap: load 16'h9999, then start → bcd_out=16'h0000; done=1 and overflow=1 in the same cycle, 5 cycles after start.
- Load validation and busy gating:
  - Load 16'h12A4 → err pulse for 1 cycle; bcd_out unchanged.
  - Load and start together → load wins, no done.
  - Start pulsed during RUN → ignored; exactly one increment occurs.
- Abort mid-run: load 16'h0999, start, then clear on the 2nd RUN cycle → bcd_out=0, IDLE, ready=1 next cycle, no done/overflow pulse.
- Reset mid-run: same setup as abort, with reset on the 2nd RUN cycle → all outputs at reset values; a subsequent start → bcd_out=16'h0001.
